// File: rtl/oai221_x2_reg_pkg.sv
// Shared OAI221 boolean helper so the lane cell and any future users agree on one definition.
package oai221_x2_reg_pkg;

   function automatic logic oai221(input logic a, input logic b1, input logic b2,
                                   input logic c1, input logic c2);
      return ~((b1 | b2) & (c1 | c2) & a);
   endfunction

endpackage

// File: rtl/oai221_x2_reg_bit.sv
// One OAI221 lane: zn = ~((b1|b2) & (c1|c2) & a).
module oai221_bit
   import oai221_x2_reg_pkg::*;
(
   input  logic a,
   input  logic b1,
   input  logic b2,
   input  logic c1,
   input  logic c2,
   output logic zn
);

   assign zn = oai221(a, b1, b2, c1, c2);

endmodule

// File: rtl/oai221_x2_reg.sv
// Bank of WIDTH independent OAI221 lanes with an optional valid-qualified output register.
module oai221_x2_reg #(
   parameter int WIDTH   = 1,
   parameter bit REG_OUT = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b1,
   input  logic [WIDTH-1:0] b2,
   input  logic [WIDTH-1:0] c1,
   input  logic [WIDTH-1:0] c2,
   output logic [WIDTH-1:0] zn,
   output logic             out_valid
);

   logic [WIDTH-1:0] zn_next;

   for (genvar i = 0; i < WIDTH; i++) begin : g_lane
      oai221_bit u_bit (
         .a  (a[i]),
         .b1 (b1[i]),
         .b2 (b2[i]),
         .c1 (c1[i]),
         .c2 (c2[i]),
         .zn (zn_next[i])
      );
   end

   if (REG_OUT) begin : g_reg
      // Reset value equals the all-zero-input result so downstream sees a legal zn.
      localparam logic [WIDTH-1:0] ZN_RST = '1;

      logic [WIDTH-1:0] zn_d, zn_q;
      logic             out_valid_d, out_valid_q;

      always_comb begin
         zn_d        = zn_q;
         out_valid_d = in_valid;
         if (in_valid) zn_d = zn_next;
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            zn_q        <= ZN_RST;
            out_valid_q <= 1'b0;
         end else begin
            zn_q        <= zn_d;
            out_valid_q <= out_valid_d;
         end
      end

      assign zn        = zn_q;
      assign out_valid = out_valid_q;
   end else begin : g_comb
      // Clock and reset have no function without the register stage.
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst_n;

      assign zn        = zn_next;
      assign out_valid = in_valid;
   end

endmodule

// File: tb/tb_oai221_x2_reg.sv
// Randomized and directed checks of oai221_x2_reg (registered 4-lane, default 1-lane, comb 4-lane).
module tb_oai221_x2_reg;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic [3:0] a, b1, b2, c1, c2;
   logic [3:0] zn_r4, zn_c4;
   logic [0:0] zn_r1;
   logic       ov_r4, ov_c4, ov_r1;

   int n_vec = 0;
   int n_err = 0;

   logic [3:0] exp_zn;
   logic       exp_v;

   always #5 clk = ~clk;

   oai221_x2_reg #(.WIDTH(4), .REG_OUT(1'b1)) u_dut_r4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
      .a(a), .b1(b1), .b2(b2), .c1(c1), .c2(c2),
      .zn(zn_r4), .out_valid(ov_r4));

   oai221_x2_reg u_dut_r1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
      .a(a[0]), .b1(b1[0]), .b2(b2[0]), .c1(c1[0]), .c2(c2[0]),
      .zn(zn_r1), .out_valid(ov_r1));

   oai221_x2_reg #(.WIDTH(4), .REG_OUT(1'b0)) u_dut_c4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
      .a(a), .b1(b1), .b2(b2), .c1(c1), .c2(c2),
      .zn(zn_c4), .out_valid(ov_c4));

   // Reference: a lane goes low only when a is set and each OR group has at least one set input.
   function automatic logic [3:0] ref_zn(input logic [3:0] ra, rb1, rb2, rc1, rc2);
      logic [3:0] r;
      for (int i = 0; i < 4; i++) begin
         int nb, nc;
         nb = int'(rb1[i]) + int'(rb2[i]);
         nc = int'(rc1[i]) + int'(rc2[i]);
         r[i] = (ra[i] == 1'b1 && nb > 0 && nc > 0) ? 1'b0 : 1'b1;
      end
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [3:0] ia, ib1, ib2, ic1, ic2);
      in_valid = v; a = ia; b1 = ib1; b2 = ib2; c1 = ic1; c2 = ic2;
   endtask

   // Check comb instance now, advance one edge, then check the registered instances.
   task automatic step(input string tag);
      #1;
      chk({tag, "_c_zn"}, 32'(zn_c4), 32'(ref_zn(a, b1, b2, c1, c2)));
      chk({tag, "_c_vld"}, 32'(ov_c4), 32'(in_valid));
      @(posedge clk);
      if (in_valid) exp_zn = ref_zn(a, b1, b2, c1, c2);
      exp_v = in_valid;
      #1;
      chk({tag, "_r4_zn"}, 32'(zn_r4), 32'(exp_zn));
      chk({tag, "_r4_vld"}, 32'(ov_r4), 32'(exp_v));
      chk({tag, "_r1_zn"}, 32'(zn_r1), 32'(exp_zn[0]));
      chk({tag, "_r1_vld"}, 32'(ov_r1), 32'(exp_v));
   endtask

   initial begin
      logic [4:0] k5;
      rst_n = 1'b0;
      drive(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
      exp_zn = 4'hF;
      exp_v  = 1'b0;
      #12;
      chk("rst_zn", 32'(zn_r4), 32'hF);
      chk("rst_vld", 32'(ov_r4), 32'h0);
      rst_n = 1'b1;

      // Exhaustive sweep, same pattern on every lane.
      for (int k = 0; k < 32; k++) begin
         k5 = 5'(k);
         drive(1'b1, {4{k5[4]}}, {4{k5[3]}}, {4{k5[2]}}, {4{k5[1]}}, {4{k5[0]}});
         step("sweep");
         case (k5)
            5'b00000, 5'b11000: chk("tt_one", 32'(zn_r1), 32'h1);
            5'b10101, 5'b11111: chk("tt_zero", 32'(zn_r1), 32'h0);
            default: ;
         endcase
      end

      // Hold: capture 10101, then invalid zeros must not disturb zn.
      drive(1'b1, 4'hF, 4'h0, 4'hF, 4'h0, 4'hF);
      step("hold_cap");
      drive(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
      step("hold");
      chk("hold_zn", 32'(zn_r4), 32'h0);
      chk("hold_vld", 32'(ov_r4), 32'h0);

      // Multi-lane directed vector.
      drive(1'b1, 4'b1111, 4'b0101, 4'b0000, 4'b0011, 4'b0000);
      step("lanes");
      chk("lanes_zn", 32'(zn_r4), 32'(4'b1110));

      // Async reset mid-stream with a pending zero-producing input.
      drive(1'b1, 4'hF, 4'h0, 4'hF, 4'h0, 4'hF);
      step("pre_rst");
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_zn", 32'(zn_r4), 32'hF);
      chk("arst_vld", 32'(ov_r4), 32'h0);
      chk("arst_zn1", 32'(zn_r1), 32'h1);
      @(posedge clk);
      #1;
      chk("rst_hold_zn", 32'(zn_r4), 32'hF);
      chk("rst_hold_vld", 32'(ov_r4), 32'h0);
      rst_n = 1'b1;
      exp_zn = 4'hF;
      exp_v  = 1'b0;
      step("post_rst");
      chk("post_rst_zn", 32'(zn_r4), 32'h0);

      // Random streaming.
      for (int t = 0; t < 1000; t++) begin
         drive($urandom_range(3) != 0, 4'($urandom), 4'($urandom), 4'($urandom),
               4'($urandom), 4'($urandom));
         step("stream");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
